// File: rtl/router_pkg.sv
// Shared definitions for the router packet transmitter.
// Holds FSM state codes, header field positions, the invalid channel code,
// the maximum payload length and small header/parity helper functions.
package router_pkg;

  localparam int MAX_LEN = 15;
  localparam int BUF_AW  = 4;

  // Transmit FSM state codes
  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_FILL = 3'd1;
  localparam logic [2:0] ST_ARB  = 3'd2;
  localparam logic [2:0] ST_HDR  = 3'd3;
  localparam logic [2:0] ST_PAY  = 3'd4;
  localparam logic [2:0] ST_PAR  = 3'd5;
  localparam logic [2:0] ST_GAP  = 3'd6;
  localparam logic [2:0] ST_CHK  = 3'd7;

  // Header byte layout
  localparam int HDR_DEST_LSB = 0;
  localparam int HDR_DEST_MSB = 1;
  localparam int HDR_LEN_LSB  = 2;
  localparam int HDR_LEN_MSB  = 5;
  localparam int HDR_RSVD_LSB = 6;
  localparam int HDR_RSVD_MSB = 7;

  // Channel 3 does not exist on the router
  localparam logic [1:0] CH_INVALID = 2'd3;

  // Build the header byte; reserved bits are always zero
  function automatic logic [7:0] make_hdr(input logic [1:0] dest, input logic [3:0] len);
    logic [7:0] h;
    h = 8'h00;
    h[HDR_DEST_MSB:HDR_DEST_LSB] = dest;
    h[HDR_LEN_MSB:HDR_LEN_LSB]   = len;
    h[HDR_RSVD_MSB:HDR_RSVD_LSB] = 2'b00;
    return h;
  endfunction

  // Even byte-wise parity: running XOR of every byte in the packet
  function automatic logic [7:0] par_step(input logic [7:0] acc, input logic [7:0] b);
    return acc ^ b;
  endfunction

endpackage

// File: rtl/router_pkt_tx_if.sv
// Command and payload handshake bundle of the packet transmitter.
//   cmd_valid/cmd_ready/cmd_dest/cmd_len/force_bad_parity : command channel
//   s_valid/s_ready/s_data                                : payload byte stream
// master: the producer of commands and bytes; slave: the transmitter.
interface router_pkt_tx_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_dest;
  logic [3:0] cmd_len;
  logic       force_bad_parity;
  logic       s_valid;
  logic       s_ready;
  logic [7:0] s_data;

  modport master (
    output cmd_valid, cmd_dest, cmd_len, force_bad_parity, s_valid, s_data,
    input  cmd_ready, s_ready
  );

  modport slave (
    input  cmd_valid, cmd_dest, cmd_len, force_bad_parity, s_valid, s_data,
    output cmd_ready, s_ready
  );
endinterface

// File: rtl/router_pkt_buf.sv
// Payload buffer: written in order during fill, then read back in order.
//   clk, resetn : clock, synchronous active-low reset
//   clr         : return both indices to zero (start of a new packet)
//   wr_en/wdata : store wdata at wr_idx and advance it
//   rd_en       : advance rd_idx; rdata always shows the entry at rd_idx
module router_pkt_buf #(
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          clr,
  input  logic          wr_en,
  input  logic [7:0]    wdata,
  input  logic          rd_en,
  output logic [7:0]    rdata,
  output logic [AW-1:0] wr_idx,
  output logic [AW-1:0] rd_idx
);

  logic [7:0]    mem_q [0:(2**AW)-1];
  logic [AW-1:0] wr_q, wr_d;
  logic [AW-1:0] rd_q, rd_d;

  // Index update: clear wins over any access
  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (clr) begin
      wr_d = '0;
      rd_d = '0;
    end else begin
      if (wr_en) begin
        wr_d = wr_q + {{(AW-1){1'b0}}, 1'b1};
      end else begin
        wr_d = wr_q;
      end
      if (rd_en) begin
        rd_d = rd_q + {{(AW-1){1'b0}}, 1'b1};
      end else begin
        rd_d = rd_q;
      end
    end
  end

  // Index registers
  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  // Storage array; contents are don't-care until written, so no reset
  always_ff @(posedge clk) begin
    if (wr_en && !clr) begin
      mem_q[wr_q] <= wdata;
    end
  end

  assign rdata  = mem_q[rd_q];
  assign wr_idx = wr_q;
  assign rd_idx = rd_q;

endmodule

// File: rtl/router_pkt_tx.sv
// Packet transmitter in front of the 3-channel router.
// Accepts a (dest,len) command and len payload bytes, buffers them, then
// sends header, payload and parity as one contiguous packet_valid burst and
// reports the router's err verdict through tx_done/tx_err.
//   clk, resetn      : clock, synchronous active-low reset
//   bus (slave)      : command and payload handshakes
//   packet_valid     : burst strobe to the router
//   datain           : byte to the router (0 when packet_valid is low)
//   rtr_busy         : router busy, holds the packet in arbitration
//   rtr_err          : router parity error, sampled after the packet
//   cmd_err          : 1-cycle pulse, command rejected
//   tx_done          : 1-cycle pulse, packet finished
//   tx_err           : verdict of the last finished packet
module router_pkt_tx #(
  parameter int MAX_LEN = 15,
  parameter int BUF_AW  = 4
) (
  input  logic              clk,
  input  logic              resetn,
  router_pkt_tx_if.slave    bus,
  output logic              packet_valid,
  output logic [7:0]        datain,
  input  logic              rtr_busy,
  input  logic              rtr_err,
  output logic              cmd_err,
  output logic              tx_done,
  output logic              tx_err
);

  import router_pkg::*;

  logic [2:0]        state_q, state_d;
  logic [1:0]        dest_q, dest_d;
  logic [3:0]        len_q, len_d;
  logic              bad_q, bad_d;
  logic [7:0]        par_q, par_d;
  logic              pv_q, pv_d;
  logic [7:0]        data_q, data_d;
  logic              cmd_ready_q, cmd_ready_d;
  logic              s_ready_q, s_ready_d;
  logic              cmd_err_q, cmd_err_d;
  logic              tx_done_q, tx_done_d;
  logic              tx_err_q, tx_err_d;

  logic              cmd_fire;
  logic              s_fire;
  logic              cmd_bad;
  logic              buf_clr;
  logic              buf_wr;
  logic              buf_rd;
  logic [7:0]        buf_rdata;
  logic [BUF_AW-1:0] wr_idx;
  logic [BUF_AW-1:0] rd_idx;

  router_pkt_buf #(.AW(BUF_AW)) u_buf (
    .clk    (clk),
    .resetn (resetn),
    .clr    (buf_clr),
    .wr_en  (buf_wr),
    .wdata  (bus.s_data),
    .rd_en  (buf_rd),
    .rdata  (buf_rdata),
    .wr_idx (wr_idx),
    .rd_idx (rd_idx)
  );

  // Handshake qualification against the registered ready flags
  always_comb begin
    cmd_fire = bus.cmd_valid & cmd_ready_q;
    s_fire   = bus.s_valid & s_ready_q;
    cmd_bad  = (bus.cmd_dest == CH_INVALID) || (bus.cmd_len == 4'd0) ||
               (int'(bus.cmd_len) > MAX_LEN);
  end

  // Next-state, parity accumulation and buffer control
  always_comb begin
    state_d   = state_q;
    dest_d    = dest_q;
    len_d     = len_q;
    bad_d     = bad_q;
    par_d     = par_q;
    cmd_err_d = 1'b0;
    tx_done_d = 1'b0;
    tx_err_d  = tx_err_q;
    buf_clr   = 1'b0;
    buf_wr    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        buf_clr = 1'b1;
        if (cmd_fire) begin
          if (cmd_bad) begin
            cmd_err_d = 1'b1;
          end else begin
            dest_d  = bus.cmd_dest;
            len_d   = bus.cmd_len;
            bad_d   = bus.force_bad_parity;
            par_d   = make_hdr(bus.cmd_dest, bus.cmd_len);
            state_d = ST_FILL;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_FILL: begin
        if (s_fire) begin
          buf_wr = 1'b1;
          par_d  = par_step(par_q, bus.s_data);
          if (wr_idx == BUF_AW'(len_q - 4'd1)) begin
            state_d = ST_ARB;
          end else begin
            state_d = ST_FILL;
          end
        end else begin
          state_d = ST_FILL;
        end
      end
      ST_ARB: begin
        if (!rtr_busy) begin
          state_d = ST_HDR;
        end else begin
          state_d = ST_ARB;
        end
      end
      ST_HDR: state_d = ST_PAY;
      ST_PAY: begin
        // rd_idx has already advanced past every byte once it equals len
        if (rd_idx == BUF_AW'(len_q)) begin
          state_d = ST_PAR;
        end else begin
          state_d = ST_PAY;
        end
      end
      ST_PAR: state_d = ST_GAP;
      ST_GAP: state_d = ST_CHK;
      ST_CHK: begin
        tx_err_d  = rtr_err;
        tx_done_d = 1'b1;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    // Read a byte on every cycle that the registered output will be payload
    buf_rd = (state_d == ST_PAY);
  end

  // Registered outputs decoded from the next state
  always_comb begin
    cmd_ready_d = (state_d == ST_IDLE);
    s_ready_d   = (state_d == ST_FILL);
    case (state_d)
      ST_HDR: begin
        pv_d   = 1'b1;
        data_d = make_hdr(dest_q, len_q);
      end
      ST_PAY: begin
        pv_d   = 1'b1;
        data_d = buf_rdata;
      end
      ST_PAR: begin
        pv_d   = 1'b1;
        data_d = par_q ^ {7'b0000000, bad_q};
      end
      default: begin
        pv_d   = 1'b0;
        data_d = 8'h00;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= ST_IDLE;
      dest_q      <= 2'd0;
      len_q       <= 4'd0;
      bad_q       <= 1'b0;
      par_q       <= 8'h00;
      pv_q        <= 1'b0;
      data_q      <= 8'h00;
      cmd_ready_q <= 1'b0;
      s_ready_q   <= 1'b0;
      cmd_err_q   <= 1'b0;
      tx_done_q   <= 1'b0;
      tx_err_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      dest_q      <= dest_d;
      len_q       <= len_d;
      bad_q       <= bad_d;
      par_q       <= par_d;
      pv_q        <= pv_d;
      data_q      <= data_d;
      cmd_ready_q <= cmd_ready_d;
      s_ready_q   <= s_ready_d;
      cmd_err_q   <= cmd_err_d;
      tx_done_q   <= tx_done_d;
      tx_err_q    <= tx_err_d;
    end
  end

  assign bus.cmd_ready = cmd_ready_q;
  assign bus.s_ready   = s_ready_q;
  assign packet_valid  = pv_q;
  assign datain        = data_q;
  assign cmd_err       = cmd_err_q;
  assign tx_done       = tx_done_q;
  assign tx_err        = tx_err_q;

endmodule

// File: tb/tb_router_pkt_tx.sv
// Directed bench for router_pkt_tx with a behavioural router input model
// that XOR-checks each burst and pulses rtr_err during the check cycle.
module tb_router_pkt_tx;

  logic       clk;
  logic       resetn;
  logic       packet_valid;
  logic [7:0] datain;
  logic       rtr_busy;
  logic       rtr_err;
  logic       cmd_err;
  logic       tx_done;
  logic       tx_err;

  router_pkt_tx_if bus();

  router_pkt_tx dut (
    .clk          (clk),
    .resetn       (resetn),
    .bus          (bus),
    .packet_valid (packet_valid),
    .datain       (datain),
    .rtr_busy     (rtr_busy),
    .rtr_err      (rtr_err),
    .cmd_err      (cmd_err),
    .tx_done      (tx_done),
    .tx_err       (tx_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_mis = 0;

  // Router model state
  logic [7:0] acc;
  logic       pv_prev;
  int         run;
  int         last_run;
  logic [7:0] beats [$];
  int         pv_cnt;
  int         cmd_err_cnt;
  int         done_cnt;

  logic [7:0] pay [0:15];

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Router input model: XOR of every burst byte must be zero
  always @(posedge clk) begin
    if (!resetn) begin
      acc     <= 8'h00;
      pv_prev <= 1'b0;
      rtr_err <= 1'b0;
      run     <= 0;
    end else begin
      pv_prev <= packet_valid;
      rtr_err <= 1'b0;
      if (packet_valid) begin
        acc <= (pv_prev ? acc : 8'h00) ^ datain;
        run <= pv_prev ? run + 1 : 1;
        beats.push_back(datain);
      end else if (pv_prev) begin
        last_run <= run;
        rtr_err  <= (acc != 8'h00);
      end
    end
  end

  // Event counters
  always @(posedge clk) begin
    if (packet_valid) pv_cnt <= pv_cnt + 1;
    if (cmd_err)      cmd_err_cnt <= cmd_err_cnt + 1;
    if (tx_done)      done_cnt <= done_cnt + 1;
  end

  task automatic send_cmd(input logic [1:0] d, input logic [3:0] l, input logic bad);
    int t;
    bus.cmd_valid = 1'b1;
    bus.cmd_dest = d;
    bus.cmd_len = l;
    bus.force_bad_parity = bad;
    t = 0;
    @(negedge clk);
    while (!bus.cmd_ready && t < 100) begin t++; @(negedge clk); end
    if (!bus.cmd_ready) check_val("cmd_ready_timeout", {31'd0, bus.cmd_ready}, 32'd1);
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    bus.force_bad_parity = 1'b0;
  endtask

  task automatic push_byte(input logic [7:0] b, input int idle);
    int t;
    bus.s_valid = 1'b0;
    repeat (idle) begin @(posedge clk); #1; end
    bus.s_valid = 1'b1;
    bus.s_data = b;
    t = 0;
    @(negedge clk);
    while (!bus.s_ready && t < 100) begin t++; @(negedge clk); end
    if (!bus.s_ready) check_val("s_ready_timeout", {31'd0, bus.s_ready}, 32'd1);
    @(posedge clk); #1;
    bus.s_valid = 1'b0;
  endtask

  task automatic send_pkt(input logic [1:0] d, input logic [3:0] l, input logic bad, input int idle);
    send_cmd(d, l, bad);
    for (int i = 0; i < int'(l); i++) push_byte(pay[i], idle);
  endtask

  task automatic wait_done(output logic err);
    int t;
    t = 0;
    @(negedge clk);
    while (!tx_done && t < 300) begin t++; @(negedge clk); end
    check_val("tx_done_seen", {31'd0, tx_done}, 32'd1);
    err = tx_err;
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    resetn = 1'b1;
  endtask

  logic       e;
  logic [7:0] p;
  int         c0, c1, c2;

  initial begin
    pv_cnt = 0; cmd_err_cnt = 0; done_cnt = 0; last_run = 0;
    bus.cmd_valid = 1'b0; bus.cmd_dest = 2'd0; bus.cmd_len = 4'd0;
    bus.force_bad_parity = 1'b0; bus.s_valid = 1'b0; bus.s_data = 8'h00;
    rtr_busy = 1'b0;
    resetn = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("rst_pv", {31'd0, packet_valid}, 32'd0);
    check_val("rst_datain", {24'd0, datain}, 32'd0);
    check_val("rst_cmd_ready", {31'd0, bus.cmd_ready}, 32'd0);
    check_val("rst_s_ready", {31'd0, bus.s_ready}, 32'd0);
    check_val("rst_flags", {29'd0, cmd_err, tx_done, tx_err}, 32'd0);
    @(posedge clk); #1;
    resetn = 1'b1;
    // Bytes offered in IDLE must be refused
    bus.s_valid = 1'b1; bus.s_data = 8'hEE;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("idle_cmd_ready", {31'd0, bus.cmd_ready}, 32'd1);
    check_val("idle_s_ready", {31'd0, bus.s_ready}, 32'd0);
    @(posedge clk); #1;
    bus.s_valid = 1'b0;

    // T1: dest 1, len 3
    beats.delete();
    pay[0] = 8'hA1; pay[1] = 8'hB2; pay[2] = 8'hC3;
    send_pkt(2'd1, 4'd3, 1'b0, 0);
    wait_done(e);
    check_val("t1_tx_err", {31'd0, e}, 32'd0);
    check_val("t1_nbeats", beats.size(), 32'd5);
    check_val("t1_run", last_run, 32'd5);
    if (beats.size() == 5) begin
      check_val("t1_hdr", {24'd0, beats[0]}, 32'h0D);
      check_val("t1_b0", {24'd0, beats[1]}, 32'hA1);
      check_val("t1_b1", {24'd0, beats[2]}, 32'hB2);
      check_val("t1_b2", {24'd0, beats[3]}, 32'hC3);
      check_val("t1_par", {24'd0, beats[4]}, 32'hDD);
    end
    @(negedge clk);
    check_val("t1_datain_idle", {24'd0, datain}, 32'h00);
    @(posedge clk); #1;

    // T2: forced bad parity
    beats.delete();
    send_pkt(2'd1, 4'd3, 1'b1, 0);
    wait_done(e);
    check_val("t2_tx_err", {31'd0, e}, 32'd1);
    if (beats.size() == 5) check_val("t2_par", {24'd0, beats[4]}, 32'hDC);
    else check_val("t2_nbeats", beats.size(), 32'd5);
    repeat (4) @(posedge clk);
    @(negedge clk);
    check_val("t2_tx_err_held", {31'd0, tx_err}, 32'd1);
    @(posedge clk); #1;

    // T6: reset during payload
    pay[0] = 8'h5A; pay[1] = 8'h6B; pay[2] = 8'h7C;
    send_pkt(2'd1, 4'd3, 1'b0, 0);
    c0 = 0;
    @(negedge clk);
    while (!(packet_valid && datain == 8'h6B) && c0 < 50) begin c0++; @(negedge clk); end
    check_val("t6_reach_b1", {24'd0, datain}, 32'h6B);
    resetn = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check_val("t6_pv_drop", {31'd0, packet_valid}, 32'd0);
    check_val("t6_datain", {24'd0, datain}, 32'd0);
    check_val("t6_readies", {30'd0, bus.cmd_ready, bus.s_ready}, 32'd0);
    check_val("t6_flags", {29'd0, cmd_err, tx_done, tx_err}, 32'd0);
    c1 = pv_cnt;
    @(posedge clk); #1;
    resetn = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_val("t6_no_parity", pv_cnt, c1);
    beats.delete();
    send_pkt(2'd1, 4'd3, 1'b0, 0);
    wait_done(e);
    check_val("t6_new_tx_err", {31'd0, e}, 32'd0);
    check_val("t6_new_nbeats", beats.size(), 32'd5);

    // T3: rejected commands (dest 3, then len 0)
    for (int k = 0; k < 2; k++) begin
      c0 = cmd_err_cnt; c1 = pv_cnt; c2 = done_cnt;
      if (k == 0) send_cmd(2'd3, 4'd2, 1'b0);
      else send_cmd(2'd1, 4'd0, 1'b0);
      @(negedge clk);
      check_val("t3_cmd_err_pulse", {31'd0, cmd_err}, 32'd1);
      @(posedge clk); #1;
      @(negedge clk);
      check_val("t3_cmd_err_low", {31'd0, cmd_err}, 32'd0);
      check_val("t3_cmd_ready", {31'd0, bus.cmd_ready}, 32'd1);
      check_val("t3_s_ready", {31'd0, bus.s_ready}, 32'd0);
      repeat (4) @(posedge clk);
      #1;
      check_val("t3_cmd_err_cnt", cmd_err_cnt, c0 + 1);
      check_val("t3_no_pv", pv_cnt, c1);
      check_val("t3_no_done", done_cnt, c2);
    end

    // T4: router busy stall after fill
    beats.delete();
    pay[0] = 8'h11; pay[1] = 8'h22;
    rtr_busy = 1'b1;
    send_pkt(2'd2, 4'd2, 1'b0, 0);
    c1 = pv_cnt;
    repeat (10) @(posedge clk);
    #1;
    check_val("t4_stall_no_pv", pv_cnt, c1);
    rtr_busy = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check_val("t4_hdr_pv", {31'd0, packet_valid}, 32'd1);
    check_val("t4_hdr_val", {24'd0, datain}, 32'h0A);
    wait_done(e);
    check_val("t4_tx_err", {31'd0, e}, 32'd0);
    check_val("t4_run", last_run, 32'd4);
    if (beats.size() == 4) check_val("t4_par", {24'd0, beats[3]}, 32'h39);
    else check_val("t4_nbeats", beats.size(), 32'd4);

    // T5: 15 bytes with s_valid gaps
    beats.delete();
    p = 8'h3C;
    for (int i = 0; i < 15; i++) begin
      pay[i] = 8'((i * 37 + 5) & 255);
      p = p ^ pay[i];
    end
    send_pkt(2'd0, 4'd15, 1'b0, 1);
    wait_done(e);
    check_val("t5_tx_err", {31'd0, e}, 32'd0);
    check_val("t5_run", last_run, 32'd17);
    if (beats.size() == 17) begin
      check_val("t5_hdr", {24'd0, beats[0]}, 32'h3C);
      c0 = 0;
      for (int i = 0; i < 15; i++) if (beats[i+1] !== pay[i]) c0++;
      check_val("t5_payload_errs", c0, 32'd0);
      check_val("t5_par", {24'd0, beats[16]}, {24'd0, p});
    end else begin
      check_val("t5_nbeats", beats.size(), 32'd17);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
